// File: rtl/rv_m_pkg.sv
// RV32M shared definitions: func3 codes, muldiv FSM encoding, iteration count
// and the sign/half selection applied to a finished 64-bit datapath value.
package rv_m_pkg;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    localparam int MD_STEPS = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    // Multiply negates the full 64-bit product before picking a half; divide
    // picks quotient (low) or remainder (high) first, then negates that word.
    function automatic logic [31:0] md_finish(input logic        is_div,
                                              input logic        sel_hi,
                                              input logic        neg,
                                              input logic [63:0] v);
        logic [63:0] p;
        logic [31:0] d;
        p = neg ? (~v + 64'd1) : v;
        d = sel_hi ? v[63:32] : v[31:0];
        if (is_div)
            return neg ? (~d + 32'd1) : d;
        return sel_hi ? p[63:32] : p[31:0];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage M-op request/result bundle. master = pipeline side, slave = unit.
interface ex_muldiv_unit_if;
    logic        md_req;
    logic [2:0]  md_func3;
    logic [31:0] md_op_a;
    logic [31:0] md_op_b;
    logic [4:0]  md_rd;
    logic        ex_flush;
    logic        ex_hold;
    logic        md_stall;
    logic        md_done;
    logic [31:0] md_result;
    logic [4:0]  md_rd_out;
    logic        md_busy;

    modport master (
        output md_req, md_func3, md_op_a, md_op_b, md_rd, ex_flush, ex_hold,
        input  md_stall, md_done, md_result, md_rd_out, md_busy
    );

    modport slave (
        input  md_req, md_func3, md_op_a, md_op_b, md_rd, ex_flush, ex_hold,
        output md_stall, md_done, md_result, md_rd_out, md_busy
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle shift-add multiply / restoring divide on magnitudes.
// acc holds {hi, lo}: product {P_hi, multiplier} or {remainder, quotient}.
module muldiv_iter_core
    import rv_m_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        run,
    input  logic        is_div,
    input  logic [31:0] lo_init,
    input  logic [31:0] op_init,
    output logic [63:0] acc_nxt,
    output logic        last
);
    logic [63:0] acc;
    logic [31:0] opnd;
    logic [5:0]  cnt;
    logic        div_q;
    logic [32:0] sum;
    logic [32:0] sh;
    logic [33:0] diff;

    // single iteration step; acc_nxt is also the final value on the last step
    always_comb begin
        sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        sh   = {acc[63:32], acc[31]};
        diff = {1'b0, sh} - {2'b00, opnd};
        if (div_q)
            acc_nxt = diff[33] ? {sh[31:0], acc[30:0], 1'b0}
                               : {diff[31:0], acc[30:0], 1'b1};
        else
            acc_nxt = {sum, acc[31:1]};
    end

    assign last = (cnt == 6'(MD_STEPS - 1));

    // load operands on capture, otherwise advance one step per busy cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            acc   <= {32'd0, lo_init};
            opnd  <= op_init;
            cnt   <= '0;
            div_q <= is_div;
        end else if (run) begin
            acc   <= acc_nxt;
            cnt   <= cnt + 6'd1;
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M iterative multiply/divide for EX: FSM, sign handling, special cases
// (div by zero, signed overflow, optional single-cycle multiply), output regs.
module ex_muldiv_unit
    import rv_m_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input logic             clk,
    input logic             rstn,
    ex_muldiv_unit_if.slave md
);
    md_state_e st, st_nxt;

    logic [XLEN-1:0]   a, b, a_mag, b_mag, fast_res, res_q;
    logic [2*XLEN-1:0] fast_prod, acc_nxt;
    logic [2:0]        f3;
    logic              is_div_in, sgn_a, sgn_b, sa, sb, div0, ovf, fast_mul;
    logic              neg_in, sel_hi_in, ld, run, last;
    logic              neg_q, sel_hi_q, is_div_q;
    logic [4:0]        rd_q;

    assign a  = md.md_op_a;
    assign b  = md.md_op_b;
    assign f3 = md.md_func3;

    // operand decode, magnitudes and fast-path results from the live ID/EX inputs
    always_comb begin
        is_div_in = f3[2];
        sgn_a     = is_div_in ? ~f3[0] : (f3 != M_MULHU);
        sgn_b     = is_div_in ? ~f3[0] : ~f3[1];
        sa        = sgn_a & a[XLEN-1];
        sb        = sgn_b & b[XLEN-1];
        a_mag     = sa ? (~a + 1'b1) : a;
        b_mag     = sb ? (~b + 1'b1) : b;
        div0      = is_div_in & (b == '0);
        ovf       = is_div_in & ~f3[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
        fast_mul  = FAST_MUL & ~is_div_in;
        // remainder follows the dividend sign, everything else sa^sb
        neg_in    = (is_div_in & f3[1]) ? sa : (sa ^ sb);
        sel_hi_in = is_div_in ? f3[1] : (f3 != M_MUL);
        fast_prod = FAST_MUL ? ({32'd0, a_mag} * {32'd0, b_mag}) : '0;
        if (div0)
            fast_res = f3[1] ? a : 32'hFFFF_FFFF;
        else if (ovf)
            fast_res = f3[1] ? 32'd0 : 32'h8000_0000;
        else
            fast_res = md_finish(1'b0, sel_hi_in, neg_in, fast_prod);
    end

    // FSM next state and capture strobe; flush overrides everything
    always_comb begin
        st_nxt = st;
        ld     = 1'b0;
        unique case (st)
            S_IDLE: if (md.md_req) begin
                ld = 1'b1;
                if (div0 | ovf | fast_mul) st_nxt = S_DONE;
                else if (is_div_in)        st_nxt = S_DIV;
                else                       st_nxt = S_MUL;
            end
            S_MUL, S_DIV: if (last) st_nxt = S_DONE;
            S_DONE:       if (!md.ex_hold) st_nxt = S_IDLE;
            default:      st_nxt = S_IDLE;
        endcase
        if (md.ex_flush) begin
            st_nxt = S_IDLE;
            ld     = 1'b0;
        end
    end

    assign run = (st == S_MUL) || (st == S_DIV);

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= S_IDLE;
        else       st <= st_nxt;
    end

    // op attributes at capture, result on fast path or final iteration
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q     <= '0;
            neg_q    <= 1'b0;
            sel_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            res_q    <= '0;
        end else begin
            if (ld) begin
                rd_q     <= md.md_rd;
                neg_q    <= neg_in;
                sel_hi_q <= sel_hi_in;
                is_div_q <= is_div_in;
                if (div0 | ovf | fast_mul) res_q <= fast_res;
            end
            if (run && last && !md.ex_flush)
                res_q <= md_finish(is_div_q, sel_hi_q, neg_q, acc_nxt);
        end
    end

    muldiv_iter_core u_core (
        .clk     (clk),
        .rstn    (rstn),
        .load    (ld),
        .run     (run),
        .is_div  (is_div_in),
        .lo_init (is_div_in ? a_mag : b_mag),
        .op_init (is_div_in ? b_mag : a_mag),
        .acc_nxt (acc_nxt),
        .last    (last)
    );

    assign md.md_stall  = md.md_req & (st != S_DONE) & ~md.ex_flush;
    assign md.md_done   = (st == S_DONE);
    assign md.md_busy   = (st != S_IDLE);
    assign md.md_result = res_q;
    assign md.md_rd_out = rd_q;
endmodule
